// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the shared binary-to-BCD converter.
package bcd_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} bcd_state_t;
    localparam int BCD_DIGITS = 4;
    localparam int BCD_MAX = 9999;
    localparam logic [4*BCD_DIGITS-1:0] BCD_SAT = 16'h9999;
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one double-dabble iteration (add 3 to digits >= 5, then shift in a bit).
module bcd_dabble_step import bcd_pkg::*; (
    input  logic [4*BCD_DIGITS-1:0] acc,
    input  logic                    bit_in,
    output logic [4*BCD_DIGITS-1:0] acc_nxt
);
    logic [4*BCD_DIGITS-1:0] adj;
    for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_dig
        assign adj[4*d +: 4] = (acc[4*d +: 4] >= 4'd5) ? acc[4*d +: 4] + 4'd3 : acc[4*d +: 4];
    end
    assign acc_nxt = {adj[4*BCD_DIGITS-2:0], bit_in};
endmodule

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin sharing of one bit-serial binary-to-BCD engine.
// Overflowing captures skip the dabble but take one SHIFT cycle so their latency is fixed.
module bcd_conv_arbiter import bcd_pkg::*; #(
    parameter int NREQ = 2,
    parameter int IN_W = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*IN_W-1:0] bin_in,
    output logic [NREQ-1:0]      grant,
    output logic [15:0]          bcd_out,
    output logic                 valid,
    output logic                 ovf,
    output logic                 busy
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(IN_W + 1);
    bcd_state_t state, state_nxt;
    logic [PW-1:0] rr_ptr, win, arb_idx;
    logic arb_hit, cap_ovf, ovf_flag, ovf_q;
    logic [IN_W-1:0] sreg, cap_val;
    logic [15:0] acc, step_out, acc_nxt, bcd_q;
    logic [CW-1:0] cnt;
    always_comb begin
        int idx;
        arb_hit = 1'b0;
        arb_idx = rr_ptr;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!arb_hit && req[idx]) begin
                arb_hit = 1'b1;
                arb_idx = PW'(idx);
            end
        end
    end
    assign cap_val = bin_in[arb_idx*IN_W +: IN_W];
    assign cap_ovf = int'(cap_val) > BCD_MAX;
    bcd_dabble_step u_step (
        .acc     (acc),
        .bit_in  (sreg[IN_W-1]),
        .acc_nxt (step_out)
    );
    assign acc_nxt = ovf_flag ? acc : step_out;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == ST_IDLE) ? (arb_hit ? ST_SHIFT : ST_IDLE) :
                    (state == ST_SHIFT) ? ((cnt == '0) ? ST_DONE : ST_SHIFT) : ST_IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            win      <= '0;
            sreg     <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
            ovf_q    <= 1'b0;
            bcd_q    <= '0;
        end else begin
            if (state == ST_IDLE && arb_hit) begin
                win      <= arb_idx;
                sreg     <= cap_val;
                ovf_flag <= cap_ovf;
                acc      <= cap_ovf ? BCD_SAT : '0;
                cnt      <= cap_ovf ? '0 : CW'(IN_W - 1);
            end
            if (state == ST_SHIFT) begin
                acc  <= acc_nxt;
                sreg <= sreg << 1;
                cnt  <= cnt - 1'b1;
                if (cnt == '0) begin
                    bcd_q <= acc_nxt;
                    ovf_q <= ovf_flag;
                end
            end
            if (state == ST_DONE) rr_ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
    end
    always_comb begin
        valid   = state == ST_DONE;
        busy    = state != ST_IDLE;
        grant   = NREQ'(state == ST_DONE) << win;
        bcd_out = bcd_q;
        ovf     = ovf_q;
    end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: directed table vectors plus contention, reset and drop sequences.
module tb_bcd_conv_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] req = '0;
    logic [13:0] b0 = '0, b1 = '0;
    logic [1:0] grant;
    logic [15:0] bcd_out;
    logic valid, ovf, busy;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    bcd_conv_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .bin_in({b1, b0}),
        .grant(grant), .bcd_out(bcd_out), .valid(valid), .ovf(ovf), .busy(busy)
    );
    typedef struct {
        logic [1:0]  r;
        logic [13:0] v0, v1;
        logic [1:0]  g;
        logic [15:0] bcd;
        logic        o;
        int          lat;
    } vec_t;
    vec_t vt[9];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask
    // Called at a negedge with inputs driven; counts edges until valid is seen.
    task automatic wait_valid(output int lat, output logic b1st);
        lat = 0;
        b1st = 1'b0;
        while (lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) b1st = busy;
            if (valid) break;
        end
    endtask
    initial begin
        int lat, nv;
        logic bb;
        vt[0] = '{2'b01, 14'd1234,  14'd0,    2'b01, 16'h1234, 1'b0, 15};
        vt[1] = '{2'b01, 14'd9999,  14'd0,    2'b01, 16'h9999, 1'b0, 15};
        vt[2] = '{2'b01, 14'd0,     14'd0,    2'b01, 16'h0000, 1'b0, 15};
        vt[3] = '{2'b01, 14'd5,     14'd0,    2'b01, 16'h0005, 1'b0, 15};
        vt[4] = '{2'b01, 14'd12000, 14'd0,    2'b01, 16'h9999, 1'b1, 2};
        vt[5] = '{2'b10, 14'd0,     14'd9876, 2'b10, 16'h9876, 1'b0, 15};
        vt[6] = '{2'b10, 14'd0,     14'd16383,2'b10, 16'h9999, 1'b1, 2};
        vt[7] = '{2'b01, 14'd10000, 14'd0,    2'b01, 16'h9999, 1'b1, 2};
        vt[8] = '{2'b10, 14'd0,     14'd100,  2'b10, 16'h0100, 1'b0, 15};
        repeat (2) @(negedge clk);
        chk("rst_outputs", {grant, valid, ovf, busy, bcd_out}, '0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {grant, valid, ovf, busy, bcd_out}, '0);
        for (int i = 0; i < 9; i++) begin
            repeat (2) @(negedge clk);
            req = vt[i].r; b0 = vt[i].v0; b1 = vt[i].v1;
            wait_valid(lat, bb);
            req = '0;
            chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("v%0d_busy", i), bb, 1'b1);
            chk($sformatf("v%0d_grant", i), grant, vt[i].g);
            chk($sformatf("v%0d_bcd", i), bcd_out, vt[i].bcd);
            chk($sformatf("v%0d_ovf", i), ovf, vt[i].o);
        end
        @(negedge clk);
        chk("hold_after_done", {valid, bcd_out}, {1'b0, 16'h0100});
        // Continuous contention: strict alternation starting at requester 0.
        repeat (2) @(negedge clk);
        req = 2'b11; b0 = 14'd42; b1 = 14'd7;
        wait_valid(lat, bb);
        chk("rr0_grant", grant, 2'b01);
        chk("rr0_bcd", bcd_out, 16'h0042);
        wait_valid(lat, bb);
        chk("rr1_gap", lat, 16);
        chk("rr1_grant", grant, 2'b10);
        chk("rr1_bcd", bcd_out, 16'h0007);
        wait_valid(lat, bb);
        req = '0;
        chk("rr2_gap", lat, 16);
        chk("rr2_grant", grant, 2'b01);
        chk("rr2_bcd", bcd_out, 16'h0042);
        repeat (3) @(negedge clk);
        chk("rr_stop_busy", busy, 1'b0);
        // Asynchronous reset in the 5th SHIFT cycle.
        req = 2'b01; b0 = 14'd555;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_outputs", {grant, valid, ovf, busy, bcd_out}, '0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid) nv++;
        end
        chk("midrst_no_valid", nv, 0);
        req = 2'b10; b1 = 14'd88;
        wait_valid(lat, bb);
        req = '0;
        chk("post_rst_latency", lat, 15);
        chk("post_rst_grant", grant, 2'b10);
        chk("post_rst_bcd", bcd_out, 16'h0088);
        // Requester drops mid-conversion; result still delivered exactly once.
        repeat (2) @(negedge clk);
        req = 2'b10; b1 = 14'd300;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        req = '0;
        b1 = 14'd1;
        lat = 0;
        while (lat < 40 && !valid) begin
            @(negedge clk);
            lat++;
        end
        chk("drop_valid_seen", valid, 1'b1);
        chk("drop_grant", grant, 2'b10);
        chk("drop_bcd", bcd_out, 16'h0300);
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid || busy) nv++;
        end
        chk("drop_no_second", nv, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
